// File: rtl/qam_cordic_sched.sv
// Shares one pipelined CORDIC core between the TX and RX carrier paths.
// Round-robin issue, tag pipeline routes each sin/cos result back home.
module qam_cordic_sched #(
  parameter int PHASE_W = 6,
  parameter int COR_LAT = 11,
  parameter int OUT_W   = 8
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst,
  input  logic                 tx_en,
  input  logic                 rx_en,
  input  logic [PHASE_W-1:0]   tx_fcw,
  input  logic [PHASE_W-1:0]   rx_fcw,
  input  logic                 tx_req,
  input  logic                 rx_req,
  output logic                 tx_ack,
  output logic                 rx_ack,
  output logic                 cor_phase_tvalid,
  output logic [7:0]           cor_phase_tdata,
  input  logic                 cor_dout_tvalid,
  input  logic [2*OUT_W-1:0]   cor_dout_tdata,
  output logic                 tx_valid,
  output logic                 rx_valid,
  output logic [OUT_W-1:0]     tx_sin,
  output logic [OUT_W-1:0]     tx_cos,
  output logic [OUT_W-1:0]     rx_sin,
  output logic [OUT_W-1:0]     rx_cos,
  output logic                 tx_zero,
  output logic                 rx_zero,
  output logic                 seq_err
);

  localparam logic ID_TX = 1'b0;
  localparam logic ID_RX = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
    logic zero;
  } tag_t;

  logic [PHASE_W-1:0] r_tx_acc;
  logic [PHASE_W-1:0] r_rx_acc;
  logic               r_last;
  logic               r_ph_vld;
  logic [7:0]         r_ph_dat;
  tag_t               r_tag [0:COR_LAT];
  logic               r_tx_vld;
  logic               r_rx_vld;
  logic [OUT_W-1:0]   r_tx_sin;
  logic [OUT_W-1:0]   r_tx_cos;
  logic [OUT_W-1:0]   r_rx_sin;
  logic [OUT_W-1:0]   r_rx_cos;
  logic               r_tx_zero;
  logic               r_rx_zero;
  logic               r_seq_err;

  logic               w_tx_elig;
  logic               w_rx_elig;
  logic               w_tx_ack;
  logic               w_rx_ack;
  logic               w_xfer;
  logic [PHASE_W-1:0] w_sel_acc;
  tag_t               w_new_tag;
  tag_t               w_head;
  logic               w_hit;
  logic [OUT_W-1:0]   w_sin;
  logic [OUT_W-1:0]   w_cos;

  // Reset also masks the grants so every output reads 0 while it is held.
  assign w_tx_elig = tx_req & tx_en & ~axi_rst;
  assign w_rx_elig = rx_req & rx_en & ~axi_rst;

  assign w_tx_ack = w_tx_elig & (~w_rx_elig | (r_last == ID_RX));
  assign w_rx_ack = w_rx_elig & (~w_tx_elig | (r_last == ID_TX));
  assign w_xfer   = w_tx_ack | w_rx_ack;

  assign w_sel_acc = w_rx_ack ? r_rx_acc : r_tx_acc;

  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_xfer;
    w_new_tag.id    = w_rx_ack ? ID_RX : ID_TX;
    w_new_tag.zero  = w_xfer & (w_sel_acc == '0);
  end

  assign w_head = r_tag[COR_LAT];
  assign w_hit  = cor_dout_tvalid & w_head.valid;
  assign w_sin  = cor_dout_tdata[2*OUT_W-1:OUT_W];
  assign w_cos  = cor_dout_tdata[OUT_W-1:0];

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_last <= ID_RX;
    end else if (w_xfer) begin
      r_last <= w_rx_ack ? ID_RX : ID_TX;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_tx_acc <= '0;
    end else if (!tx_en) begin
      r_tx_acc <= '0;
    end else if (w_tx_ack) begin
      r_tx_acc <= r_tx_acc + tx_fcw;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_rx_acc <= '0;
    end else if (!rx_en) begin
      r_rx_acc <= '0;
    end else if (w_rx_ack) begin
      r_rx_acc <= r_rx_acc + rx_fcw;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_ph_vld <= 1'b0;
      r_ph_dat <= '0;
    end else begin
      r_ph_vld <= w_xfer;
      if (w_xfer) begin
        r_ph_dat <= 8'($signed(w_sel_acc));
      end
    end
  end

  // Stage 0 sits beside the phase register; stage COR_LAT meets dout.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      for (int i = 0; i <= COR_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_new_tag;
      for (int i = 1; i <= COR_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_tx_vld  <= 1'b0;
      r_tx_sin  <= '0;
      r_tx_cos  <= '0;
      r_tx_zero <= 1'b0;
    end else begin
      r_tx_vld  <= w_hit & (w_head.id == ID_TX);
      r_tx_zero <= w_hit & (w_head.id == ID_TX) & w_head.zero;
      if (w_hit && w_head.id == ID_TX) begin
        r_tx_sin <= w_sin;
        r_tx_cos <= w_cos;
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_rx_vld  <= 1'b0;
      r_rx_sin  <= '0;
      r_rx_cos  <= '0;
      r_rx_zero <= 1'b0;
    end else begin
      r_rx_vld  <= w_hit & (w_head.id == ID_RX);
      r_rx_zero <= w_hit & (w_head.id == ID_RX) & w_head.zero;
      if (w_hit && w_head.id == ID_RX) begin
        r_rx_sin <= w_sin;
        r_rx_cos <= w_cos;
      end
    end
  end

  // Any disagreement between core and tag valid means lost alignment.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_seq_err <= 1'b0;
    end else if (cor_dout_tvalid != w_head.valid) begin
      r_seq_err <= 1'b1;
    end
  end

  assign tx_ack           = w_tx_ack;
  assign rx_ack           = w_rx_ack;
  assign cor_phase_tvalid = r_ph_vld;
  assign cor_phase_tdata  = r_ph_dat;
  assign tx_valid         = r_tx_vld;
  assign rx_valid         = r_rx_vld;
  assign tx_sin           = r_tx_sin;
  assign tx_cos           = r_tx_cos;
  assign rx_sin           = r_rx_sin;
  assign rx_cos           = r_rx_cos;
  assign tx_zero          = r_tx_zero;
  assign rx_zero          = r_rx_zero;
  assign seq_err          = r_seq_err;

endmodule

// File: tb/tb_qam_cordic_sched.sv
// Directed bench for qam_cordic_sched with a delay-line CORDIC stand-in
// whose output is {phase, phase^0xA5}.
module tb_qam_cordic_sched;

  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b1;
  logic        tx_en = 1'b0, rx_en = 1'b0;
  logic [5:0]  tx_fcw = '0, rx_fcw = '0;
  logic        tx_req = 1'b0, rx_req = 1'b0;
  logic        tx_ack, rx_ack;
  logic        cor_phase_tvalid;
  logic [7:0]  cor_phase_tdata;
  logic        cor_dout_tvalid;
  logic [15:0] cor_dout_tdata;
  logic        tx_valid, rx_valid;
  logic [7:0]  tx_sin, tx_cos, rx_sin, rx_cos;
  logic        tx_zero, rx_zero, seq_err;

  always #5 axi_clk = ~axi_clk;

  qam_cordic_sched dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .tx_en(tx_en), .rx_en(rx_en),
    .tx_fcw(tx_fcw), .rx_fcw(rx_fcw),
    .tx_req(tx_req), .rx_req(rx_req),
    .tx_ack(tx_ack), .rx_ack(rx_ack),
    .cor_phase_tvalid(cor_phase_tvalid),
    .cor_phase_tdata(cor_phase_tdata),
    .cor_dout_tvalid(cor_dout_tvalid),
    .cor_dout_tdata(cor_dout_tdata),
    .tx_valid(tx_valid), .rx_valid(rx_valid),
    .tx_sin(tx_sin), .tx_cos(tx_cos),
    .rx_sin(rx_sin), .rx_cos(rx_cos),
    .tx_zero(tx_zero), .rx_zero(rx_zero),
    .seq_err(seq_err)
  );

  // Core stand-in: latency = lat_m1 + 1 cycles from phase valid to dout.
  logic [3:0]  lat_m1 = 4'd10;
  logic        pv [0:15];
  logic [15:0] pd [0:15];

  always @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      for (int i = 0; i < 16; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= cor_phase_tvalid;
      pd[0] <= {cor_phase_tdata, cor_phase_tdata ^ 8'hA5};
      for (int i = 1; i < 16; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign cor_dout_tvalid = pv[lat_m1];
  assign cor_dout_tdata  = pd[lat_m1];

  int          cyc = 0;
  logic        q_gnt [$];
  int          q_gc  [$];
  logic [7:0]  q_ph  [$];
  logic [16:0] q_tx  [$];
  logic [16:0] q_rx  [$];
  int          q_txc [$];
  int          n_both = 0;
  int          err_cyc = -1;

  always @(posedge axi_clk) cyc <= cyc + 1;

  always @(negedge axi_clk) begin
    if (!axi_rst) begin
      if (tx_ack && rx_ack) n_both++;
      if (tx_ack) begin q_gnt.push_back(1'b0); q_gc.push_back(cyc); end
      if (rx_ack) begin q_gnt.push_back(1'b1); q_gc.push_back(cyc); end
      if (cor_phase_tvalid) q_ph.push_back(cor_phase_tdata);
      if (tx_valid) begin
        q_tx.push_back({tx_zero, tx_cos, tx_sin});
        q_txc.push_back(cyc);
      end
      if (rx_valid) q_rx.push_back({rx_zero, rx_cos, rx_sin});
      if (seq_err && err_cyc < 0) err_cyc = cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sx(int p);
    logic [5:0] v;
    v = 6'(p);
    return {{2{v[5]}}, v};
  endfunction

  function automatic logic [16:0] res(int p, bit z);
    logic [7:0] s;
    s = sx(p);
    return {z, s ^ 8'hA5, s};
  endfunction

  task automatic chk_ph(string nm, int k, int p);
    logic [7:0] a;
    a = (k < q_ph.size()) ? q_ph[k] : 8'h5A;
    if (k >= q_ph.size()) a = ~sx(p);
    chk(nm, {24'd0, a}, {24'd0, sx(p)});
  endtask

  task automatic chk_res(string nm, logic [16:0] q [$], int k, int p, bit z);
    logic [16:0] a;
    a = (k < q.size()) ? q[k] : ~res(p, z);
    chk(nm, {15'd0, a}, {15'd0, res(p, z)});
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  task automatic clr();
    q_gnt.delete(); q_gc.delete(); q_ph.delete();
    q_tx.delete(); q_rx.delete(); q_txc.delete();
    n_both = 0;
    err_cyc = -1;
  endtask

  task automatic do_reset();
    axi_rst = 1'b1;
    tx_en = 1'b0; rx_en = 1'b0;
    tx_req = 1'b0; rx_req = 1'b0;
    tx_fcw = '0; rx_fcw = '0;
    step(2);
    axi_rst = 1'b0;
    clr();
  endtask

  function automatic logic [63:0] all_outs();
    return {tx_ack, rx_ack, cor_phase_tvalid, cor_phase_tdata,
            tx_valid, rx_valid, tx_sin, tx_cos, rx_sin, rx_cos,
            tx_zero, rx_zero, seq_err};
  endfunction

  typedef struct {
    logic [3:0] in;
    logic [1:0] exp;
  } arb_vec_t;

  arb_vec_t tbl [8];

  initial begin
    // {tx_en, rx_en, tx_req, rx_req} -> {tx_ack, rx_ack}, last = RX
    tbl[0] = '{4'b1111, 2'b10};
    tbl[1] = '{4'b1110, 2'b10};
    tbl[2] = '{4'b1101, 2'b01};
    tbl[3] = '{4'b1011, 2'b10};
    tbl[4] = '{4'b0111, 2'b01};
    tbl[5] = '{4'b0011, 2'b00};
    tbl[6] = '{4'b1100, 2'b00};
    tbl[7] = '{4'b0110, 2'b00};

    do_reset();
    chk("reset_outputs", all_outs()[31:0], 32'd0);
    chk("reset_outputs_hi", all_outs()[63:32], 32'd0);

    foreach (tbl[i]) begin
      {tx_en, rx_en, tx_req, rx_req} = tbl[i].in;
      #1;
      chk($sformatf("arb_vec%0d", i), {30'd0, tx_ack, rx_ack},
          {30'd0, tbl[i].exp});
      {tx_en, rx_en, tx_req, rx_req} = 4'b0000;
      step(1);
    end

    // Single channel stepping with wrap
    do_reset();
    tx_en = 1'b1; tx_fcw = 6'd1; tx_req = 1'b1;
    step(70);
    tx_req = 1'b0;
    step(20);
    chk("t1_nphase", q_ph.size(), 70);
    for (int k = 0; k < 70; k++) chk_ph("t1_phase", k, k % 64);
    chk("t1_nres", q_tx.size(), 70);
    for (int k = 0; k < 70; k++)
      chk_res("t1_res", q_tx, k, k % 64, (k % 64) == 0);
    chk("t1_latency",
        (q_txc.size() > 0 && q_gc.size() > 0) ? q_txc[0] - q_gc[0] : -1, 13);
    chk("t1_rx_quiet", q_rx.size(), 0);

    // Contention
    do_reset();
    tx_en = 1'b1; rx_en = 1'b1;
    tx_fcw = 6'd1; rx_fcw = 6'd3;
    tx_req = 1'b1; rx_req = 1'b1;
    step(20);
    tx_req = 1'b0; rx_req = 1'b0;
    step(20);
    chk("t2_ngrant", q_gnt.size(), 20);
    for (int k = 0; k < 20; k++)
      chk("t2_order", (k < q_gnt.size()) ? {31'd0, q_gnt[k]} : 32'd9,
          k % 2);
    chk("t2_dual_ack", n_both, 0);
    chk("t2_ntx", q_tx.size(), 10);
    chk("t2_nrx", q_rx.size(), 10);
    for (int k = 0; k < 10; k++) begin
      chk_res("t2_tx", q_tx, k, k, k == 0);
      chk_res("t2_rx", q_rx, k, 3 * k, k == 0);
    end

    // Wrap with large step
    do_reset();
    tx_en = 1'b1; tx_fcw = 6'h1D; tx_req = 1'b1;
    step(12);
    tx_req = 1'b0;
    step(18);
    chk("t3_nres", q_tx.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk_ph("t3_phase", k, (k * 29) % 64);
      chk_res("t3_res", q_tx, k, (k * 29) % 64, k == 0);
    end

    // Disable mid-flight
    do_reset();
    tx_en = 1'b1; tx_fcw = 6'd1; tx_req = 1'b1;
    step(5);
    tx_req = 1'b0;
    step(3);
    tx_en = 1'b0;
    step(12);
    tx_en = 1'b1; tx_req = 1'b1;
    step(1);
    tx_req = 1'b0;
    step(20);
    chk("t4_nres", q_tx.size(), 6);
    for (int k = 0; k < 5; k++) chk_res("t4_inflight", q_tx, k, k, k == 0);
    chk_res("t4_reenable", q_tx, 5, 0, 1'b1);

    // Misaligned core latency
    do_reset();
    lat_m1 = 4'd11;
    chk("t5_err_clear", {31'd0, seq_err}, 0);
    tx_en = 1'b1; tx_fcw = 6'd1; tx_req = 1'b1;
    step(1);
    tx_req = 1'b0;
    step(20);
    chk("t5_err_set", {31'd0, seq_err}, 1);
    chk("t5_err_cycle",
        (q_gc.size() > 0 && err_cyc >= 0) ? err_cyc - q_gc[0] : -1, 13);
    step(10);
    chk("t5_err_sticky", {31'd0, seq_err}, 1);
    chk("t5_no_result", q_tx.size(), 0);
    lat_m1 = 4'd10;
    do_reset();
    chk("t5_err_reset", {31'd0, seq_err}, 0);

    // Asynchronous reset in mid-stream
    tx_en = 1'b1; rx_en = 1'b1;
    tx_fcw = 6'd1; rx_fcw = 6'd3;
    tx_req = 1'b1; rx_req = 1'b1;
    step(16);
    chk("t6_busy", {31'd0, tx_valid | rx_valid}, 1);
    #1 axi_rst = 1'b1;
    #1;
    chk("t6_rst_lo", all_outs()[31:0], 32'd0);
    chk("t6_rst_hi", all_outs()[63:32], 32'd0);
    #1 axi_rst = 1'b0;
    clr();
    step(8);
    tx_req = 1'b0; rx_req = 1'b0;
    step(20);
    chk("t6_first_gnt", (q_gnt.size() > 0) ? {31'd0, q_gnt[0]} : 32'd9, 0);
    chk("t6_second_gnt", (q_gnt.size() > 1) ? {31'd0, q_gnt[1]} : 32'd9, 1);
    chk_ph("t6_first_phase", 0, 0);
    chk_res("t6_tx_res0", q_tx, 0, 0, 1'b1);
    chk_res("t6_rx_res0", q_rx, 0, 0, 1'b1);
    chk("t6_no_err", {31'd0, seq_err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
